// File: rtl/gol_setup_sequencer.sv
// Game of Life central controller: button-to-move qualification, selection cursor, phase FSM and generation strobe.
// Define CURSOR_WRAP_EN to make the cursor wrap modulo the grid size instead of saturating at the edges.
module gol_setup_sequencer #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int TICK_DIV = 25000000,
  parameter int GEN_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    leftButton,
  input  logic                    rightButton,
  input  logic                    upButton,
  input  logic                    downButton,
  input  logic                    confirmSeedSwitch,
  input  logic                    startGameSwitch,
  input  logic                    allDead,
  output logic [$clog2(ROWS)-1:0] cursorRow,
  output logic [$clog2(COLS)-1:0] cursorCol,
  output logic [ROWS-1:0]         rowSel,
  output logic [COLS-1:0]         colSel,
  output logic                    moveLeft,
  output logic                    moveRight,
  output logic                    moveUp,
  output logic                    moveDown,
  output logic                    confirmPulse,
  output logic                    loadSeed,
  output logic                    genStep,
  output logic [GEN_W-1:0]        generation,
  output logic [1:0]              phase
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  // Cursor value taken when stepping past the low (0) or high (MAX) edge.
`ifdef CURSOR_WRAP_EN
  localparam logic [ROW_W-1:0] ROW_PAST_LO = ROW_MAX;
  localparam logic [ROW_W-1:0] ROW_PAST_HI = '0;
  localparam logic [COL_W-1:0] COL_PAST_LO = COL_MAX;
  localparam logic [COL_W-1:0] COL_PAST_HI = '0;
`else
  localparam logic [ROW_W-1:0] ROW_PAST_LO = '0;
  localparam logic [ROW_W-1:0] ROW_PAST_HI = ROW_MAX;
  localparam logic [COL_W-1:0] COL_PAST_LO = '0;
  localparam logic [COL_W-1:0] COL_PAST_HI = COL_MAX;
`endif

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } phase_t;

  phase_t           state;
  logic [3:0]       buttons;
  logic [3:0]       prevButtons;
  logic [3:0]       pressed;
  logic             prevConfirm;
  logic             moveValid;
  logic             confirmRise;
  logic [CNT_W-1:0] prescaler;
  logic [ROW_W-1:0] nextRow;
  logic [COL_W-1:0] nextCol;

  assign buttons     = {leftButton, rightButton, upButton, downButton};
  assign pressed     = buttons & ~prevButtons;
  assign moveValid   = $onehot(buttons) && (pressed == buttons);
  assign confirmRise = confirmSeedSwitch && !prevConfirm;

  assign rowSel = ROWS'(1) << cursorRow;
  assign colSel = COLS'(1) << cursorCol;
  assign phase  = state;

  // Candidate cursor position; only used when exactly one button qualifies.
  always_comb begin
    nextRow = cursorRow;
    nextCol = cursorCol;
    if (leftButton)
      nextCol = (cursorCol == '0) ? COL_PAST_LO : cursorCol - COL_W'(1);
    else if (rightButton)
      nextCol = (cursorCol == COL_MAX) ? COL_PAST_HI : cursorCol + COL_W'(1);
    else if (upButton)
      nextRow = (cursorRow == '0) ? ROW_PAST_LO : cursorRow - ROW_W'(1);
    else if (downButton)
      nextRow = (cursorRow == ROW_MAX) ? ROW_PAST_HI : cursorRow + ROW_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SETUP;
      prevButtons  <= '0;
      prevConfirm  <= 1'b0;
      cursorRow    <= '0;
      cursorCol    <= '0;
      moveLeft     <= 1'b0;
      moveRight    <= 1'b0;
      moveUp       <= 1'b0;
      moveDown     <= 1'b0;
      confirmPulse <= 1'b0;
      loadSeed     <= 1'b0;
      genStep      <= 1'b0;
      generation   <= '0;
      prescaler    <= '0;
    end else begin
      prevButtons  <= buttons;
      prevConfirm  <= confirmSeedSwitch;
      moveLeft     <= 1'b0;
      moveRight    <= 1'b0;
      moveUp       <= 1'b0;
      moveDown     <= 1'b0;
      confirmPulse <= 1'b0;
      loadSeed     <= 1'b0;
      genStep      <= 1'b0;
      case (state)
        SETUP: begin
          // Starting the game wins over any move or confirm in the same cycle.
          if (startGameSwitch) begin
            state    <= LOAD;
            loadSeed <= 1'b1;
          end else begin
            if (moveValid) begin
              cursorRow <= nextRow;
              cursorCol <= nextCol;
              moveLeft  <= leftButton;
              moveRight <= rightButton;
              moveUp    <= upButton;
              moveDown  <= downButton;
            end
            if (confirmRise) confirmPulse <= 1'b1;
          end
        end
        LOAD: begin
          state     <= RUN;
          prescaler <= '0;
        end
        RUN: begin
          if (allDead) begin
            state <= HALT;
          end else if (prescaler == CNT_MAX) begin
            prescaler <= '0;
            genStep   <= 1'b1;
            if (generation != '1) generation <= generation + GEN_W'(1);
          end else begin
            prescaler <= prescaler + CNT_W'(1);
          end
        end
        HALT: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gol_setup_sequencer.sv
// Randomized self-checking bench for gol_setup_sequencer against an integer-level model of the game controller.
module tb_gol_setup_sequencer;

  localparam int ROWS     = 16;
  localparam int COLS     = 16;
  localparam int TICK_DIV = 4;
  localparam int GEN_W    = 3;
  localparam int GEN_MAX  = (1 << GEN_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        leftButton = 1'b0, rightButton = 1'b0, upButton = 1'b0, downButton = 1'b0;
  logic        confirmSeedSwitch = 1'b0, startGameSwitch = 1'b0, allDead = 1'b0;
  logic [3:0]  cursorRow;
  logic [3:0]  cursorCol;
  logic [15:0] rowSel;
  logic [15:0] colSel;
  logic        moveLeft, moveRight, moveUp, moveDown;
  logic        confirmPulse, loadSeed, genStep;
  logic [GEN_W-1:0] generation;
  logic [1:0]  phase;

  gol_setup_sequencer #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV), .GEN_W(GEN_W)) dut (
    .clk(clk), .reset(reset),
    .leftButton(leftButton), .rightButton(rightButton), .upButton(upButton), .downButton(downButton),
    .confirmSeedSwitch(confirmSeedSwitch), .startGameSwitch(startGameSwitch), .allDead(allDead),
    .cursorRow(cursorRow), .cursorCol(cursorCol), .rowSel(rowSel), .colSel(colSel),
    .moveLeft(moveLeft), .moveRight(moveRight), .moveUp(moveUp), .moveDown(moveDown),
    .confirmPulse(confirmPulse), .loadSeed(loadSeed), .genStep(genStep),
    .generation(generation), .phase(phase)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  bit chkEn = 1'b0;
  int rightPulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: cursor as plain integers, RUN progress as the number of RUN edges survived.
  int       mRow = 0, mCol = 0, mPhase = 0, mRunEdges = 0;
  bit [3:0] mPrevB = '0;
  bit       mPrevC = 1'b0;
  bit [3:0] mMoves = '0;
  bit       mConf = 1'b0, mLoad = 1'b0, mGs = 1'b0;

  function automatic int moveCoord(int v, int d, int size);
    int t;
    t = v + d;
`ifdef CURSOR_WRAP_EN
    return (t + size) % size;
`else
    if (t < 0) return 0;
    if (t > size - 1) return size - 1;
    return t;
`endif
  endfunction

  function automatic int modelGen();
    int g;
    g = mRunEdges / TICK_DIV;
    return (g > GEN_MAX) ? GEN_MAX : g;
  endfunction

  always @(posedge clk or negedge reset) begin
    bit [3:0] b;
    if (!reset) begin
      mRow = 0; mCol = 0; mPhase = 0; mRunEdges = 0;
      mPrevB = '0; mPrevC = 1'b0; mMoves = '0; mConf = 1'b0; mLoad = 1'b0; mGs = 1'b0;
    end else begin
      b = {leftButton, rightButton, upButton, downButton};
      mMoves = '0; mConf = 1'b0; mLoad = 1'b0; mGs = 1'b0;
      case (mPhase)
        0: if (startGameSwitch) begin
             mPhase = 1; mLoad = 1'b1;
           end else begin
             if ($countones(b) == 1 && (b & mPrevB) == 4'b0) begin
               mMoves = b;
               if (b[3]) mCol = moveCoord(mCol, -1, COLS);
               if (b[2]) mCol = moveCoord(mCol, 1, COLS);
               if (b[1]) mRow = moveCoord(mRow, -1, ROWS);
               if (b[0]) mRow = moveCoord(mRow, 1, ROWS);
             end
             if (confirmSeedSwitch && !mPrevC) mConf = 1'b1;
           end
        1: begin mPhase = 2; mRunEdges = 0; end
        2: if (allDead) mPhase = 3;
           else begin
             mRunEdges++;
             mGs = (mRunEdges % TICK_DIV) == 0;
           end
        default: ;
      endcase
      mPrevB = b;
      mPrevC = confirmSeedSwitch;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      check("cursorRow", 32'(cursorRow), 32'(mRow));
      check("cursorCol", 32'(cursorCol), 32'(mCol));
      check("rowSel", 32'(rowSel), 32'(1) << mRow);
      check("colSel", 32'(colSel), 32'(1) << mCol);
      check("moves", 32'({moveLeft, moveRight, moveUp, moveDown}), 32'(mMoves));
      check("confirmPulse", 32'(confirmPulse), 32'(mConf));
      check("loadSeed", 32'(loadSeed), 32'(mLoad));
      check("genStep", 32'(genStep), 32'(mGs));
      check("generation", 32'(generation), 32'(modelGen()));
      check("phase", 32'(phase), 32'(mPhase));
      if (moveRight) rightPulses++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic randomInputs();
    int r;
    r = $urandom_range(0, 9);
    {leftButton, rightButton, upButton, downButton} = 4'b0;
    if (r >= 6 && r <= 8) begin
      case ($urandom_range(0, 3))
        0: leftButton = 1'b1;
        1: rightButton = 1'b1;
        2: upButton = 1'b1;
        default: downButton = 1'b1;
      endcase
    end else if (r == 9) begin
      {leftButton, rightButton, upButton, downButton} = 4'($urandom);
    end
    confirmSeedSwitch = ($urandom_range(0, 3) == 0);
  endtask

  task automatic clearInputs();
    {leftButton, rightButton, upButton, downButton} = 4'b0;
    confirmSeedSwitch = 1'b0;
  endtask

  task automatic checkResetLits(input string tag);
    check({tag, "_phase"}, 32'(phase), 32'd0);
    check({tag, "_row"}, 32'(cursorRow), 32'd0);
    check({tag, "_col"}, 32'(cursorCol), 32'd0);
    check({tag, "_rowSel"}, 32'(rowSel), 32'h0001);
    check({tag, "_colSel"}, 32'(colSel), 32'h0001);
    check({tag, "_pulses"}, 32'({moveLeft, moveRight, moveUp, moveDown, confirmPulse, loadSeed, genStep}), 32'd0);
    check({tag, "_gen"}, 32'(generation), 32'd0);
  endtask

  // Asynchronous reset asserted between edges, held across one posedge.
  task automatic pulseReset(input string tag);
    #2 reset = 1'b0;
    #1 checkResetLits(tag);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int guard;
    repeat (3) tick();
    checkResetLits("reset");
    reset = 1'b1;
    chkEn = 1'b1;

    // Three right presses with 2-cycle gaps.
    for (int i = 0; i < 3; i++) begin
      rightButton = 1'b1; tick();
      rightButton = 1'b0; tick(); tick();
    end
    check("lit_col3", 32'(cursorCol), 32'd3);
    check("lit_colSel8", 32'(colSel), 32'h0008);
    check("lit_rightPulses", 32'(rightPulses), 32'd3);

    // Two buttons together, then release one: no edge remains.
    leftButton = 1'b1; upButton = 1'b1; repeat (3) tick();
    upButton = 1'b0; repeat (3) tick();
    leftButton = 1'b0; tick();
    check("lit_holdCol", 32'(cursorCol), 32'd3);
    check("lit_holdRow", 32'(cursorRow), 32'd0);

    pulseReset("midSetupReset");

    // Edge behaviour at (0,0).
    upButton = 1'b1; tick();
`ifdef CURSOR_WRAP_EN
    check("lit_upEdgeRow", 32'(cursorRow), 32'd15);
`else
    check("lit_upEdgeRow", 32'(cursorRow), 32'd0);
`endif
    check("lit_upPulse", 32'(moveUp), 32'd1);
    upButton = 1'b0; tick();
    leftButton = 1'b1; tick();
`ifdef CURSOR_WRAP_EN
    check("lit_leftEdgeCol", 32'(cursorCol), 32'd15);
`else
    check("lit_leftEdgeCol", 32'(cursorCol), 32'd0);
`endif
    leftButton = 1'b0; tick();

    // Random cursor wandering in SETUP.
    for (int i = 0; i < 300; i++) begin
      randomInputs(); tick();
    end
    clearInputs(); tick();

    // Start: LOAD for one cycle, then RUN with strobes every TICK_DIV cycles.
    rightButton = 1'b1;
    startGameSwitch = 1'b1; tick();
    check("lit_loadSeed", 32'(loadSeed), 32'd1);
    check("lit_phaseLoad", 32'(phase), 32'd1);
    check("lit_startDropsMove", 32'(moveRight), 32'd0);
    startGameSwitch = 1'b0; rightButton = 1'b0; tick();
    check("lit_phaseRun", 32'(phase), 32'd2);
    for (int i = 0; i < 12; i++) begin
      randomInputs(); tick();
    end
    check("lit_gen3", 32'(generation), 32'd3);
    check("lit_genStep3", 32'(genStep), 32'd1);

    // allDead on a strobe-due cycle.
    guard = 0;
    while (((mRunEdges + 1) % TICK_DIV) != 0 && guard < 10) begin
      randomInputs(); tick(); guard++;
    end
    if (guard >= 10) check("alignTimeout", 32'(guard), 32'd0);
    allDead = 1'b1; tick();
    check("lit_halt", 32'(phase), 32'd3);
    check("lit_haltNoStep", 32'(genStep), 32'd0);
    check("lit_haltGen", 32'(generation), 32'd3);
    for (int i = 0; i < 10; i++) begin
      randomInputs(); allDead = 1'($urandom); tick();
    end
    clearInputs(); allDead = 1'b0;
    pulseReset("haltReset");

    // Second game: generation saturates while strobes continue.
    startGameSwitch = 1'b1; tick();
    startGameSwitch = 1'b0;
    for (int i = 0; i < 40; i++) begin
      randomInputs(); tick();
    end
    check("lit_genSat", 32'(generation), 32'(GEN_MAX));
    for (int i = 0; i < 8; i++) begin
      randomInputs(); tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
